// File: rtl/adder_share_arbiter_if.sv
// adder_share_arbiter_if
// Bundles the requester-side bus of the shared adder arbiter.
//   req      : per-requester level request (N_REQ bits)
//   op_a     : packed operand A, requester i at [i*WIDTH +: WIDTH]
//   op_b     : packed operand B, same packing as op_a
//   ack      : one-hot, one-cycle completion pulse
//   result   : WIDTH-bit sum, valid while ack is nonzero, otherwise held
//   carry    : carry-out of the sum, same validity as result
//   busy     : high whenever the arbiter is servicing a request
//   grant_id : index of the granted requester, valid while busy
// The master modport is the requester side; the slave modport is the arbiter.
interface adder_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] op_a;
  logic [N_REQ*WIDTH-1:0] op_b;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       result;
  logic                   carry;
  logic                   busy;
  logic [IDW-1:0]         grant_id;

  modport master (
    output req, op_a, op_b,
    input  ack, result, carry, busy, grant_id
  );

  modport slave (
    input  req, op_a, op_b,
    output ack, result, carry, busy, grant_id
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
// Time-multiplexes one registered WIDTH-bit adder between N_REQ requesters
// using round-robin arbitration. One operation takes three cycles
// (IDLE -> EXEC -> DONE) and back-to-back requests run without a bubble.
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : asynchronous active-high reset
//   bus : adder_share_arbiter_if slave modport (req/op_a/op_b in,
//         ack/result/carry/busy/grant_id out)
module adder_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  adder_share_arbiter_if.slave  bus
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   grant_q;
  logic [WIDTH-1:0] latchedA_q;
  logic [WIDTH-1:0] latchedB_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic [N_REQ-1:0] ack_q;
  logic             busy_q;

  logic [IDW-1:0]   winner_d;
  logic [IDW-1:0]   nextPtr_d;
  logic [WIDTH:0]   sum_d;
  logic [IDW:0]     cand;
  logic             found;

  // Round-robin search: walk ptr, ptr+1, ... modulo N_REQ and take the first
  // requester that is asserting. cand carries one extra bit so the wrap
  // comparison against N_REQ works for non-power-of-two requester counts.
  always_comb begin
    winner_d = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N_REQ)) begin
        cand = cand - (IDW+1)'(N_REQ);
      end
      if (!found && bus.req[cand[IDW-1:0]]) begin
        found    = 1'b1;
        winner_d = cand[IDW-1:0];
      end
    end
  end

  // The pointer moves just past the requester that was served, which is
  // what stops one requester winning twice in a row while others wait.
  always_comb begin
    nextPtr_d = '0;
    if (grant_q != IDW'(N_REQ - 1)) begin
      nextPtr_d = grant_q + IDW'(1);
    end
  end

  assign sum_d = {1'b0, latchedA_q} + {1'b0, latchedB_q};

  // Operands are captured only on the IDLE->EXEC edge, so requesters may
  // change or withdraw them afterwards without affecting the operation.
  // An asynchronous reset drops any in-flight operation without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      latchedA_q <= '0;
      latchedB_q <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
          if (|bus.req) begin
            latchedA_q <= bus.op_a[int'(winner_d)*WIDTH +: WIDTH];
            latchedB_q <= bus.op_b[int'(winner_d)*WIDTH +: WIDTH];
            grant_q    <= winner_d;
            busy_q     <= 1'b1;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          {carry_q, result_q} <= sum_d;
          ack_q               <= {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;
          state_q             <= DONE;
        end
        DONE: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= nextPtr_d;
          state_q <= IDLE;
        end
        default: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack      = ack_q;
  assign bus.result   = result_q;
  assign bus.carry    = carry_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_q;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter
// Directed bench for adder_share_arbiter with N_REQ=4, WIDTH=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_adder_share_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  adder_share_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

  adder_share_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check, reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Places one requester's operands on the packed buses.
  task automatic applyStimulus(input int id, input logic [7:0] a,
                               input logic [7:0] b);
    bus.op_a[id*8 +: 8] = a;
    bus.op_b[id*8 +: 8] = b;
  endtask

  // Polls falling edges until ack is nonzero or the budget runs out.
  task automatic waitAck(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (bus.ack == 4'b0000 && cycles < 8);
  endtask

  // One isolated operation: grant check, ack/result check, release check.
  task automatic doOp(input string tag, input int id, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] expRes,
                      input logic expCarry);
    int cycles;
    applyStimulus(id, a, b);
    bus.req = 4'b0001 << id;
    @(negedge clk);
    checkOutput({tag, " busy@grant"}, 32'(bus.busy), 32'd1);
    checkOutput({tag, " grant_id"}, 32'(bus.grant_id), 32'(id));
    checkOutput({tag, " ack@grant"}, 32'(bus.ack), 32'd0);
    waitAck(cycles);
    checkOutput({tag, " ack latency"}, 32'(cycles), 32'd1);
    checkOutput({tag, " ack"}, 32'(bus.ack), 32'(4'b0001 << id));
    checkOutput({tag, " result"}, 32'(bus.result), 32'(expRes));
    checkOutput({tag, " carry"}, 32'(bus.carry), 32'(expCarry));
    checkOutput({tag, " busy@ack"}, 32'(bus.busy), 32'd1);
    checkOutput({tag, " grant@ack"}, 32'(bus.grant_id), 32'(id));
    bus.req = 4'b0000;
    @(negedge clk);
    checkOutput({tag, " ack after"}, 32'(bus.ack), 32'd0);
    checkOutput({tag, " busy after"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, " result hold"}, 32'(bus.result), 32'(expRes));
  endtask

  initial begin
    int cycles;
    int ackCount;
    logic [3:0] expAck;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus.op_a = '0;
    bus.op_b = '0;

    // Reset values.
    #1;
    checkOutput("reset ack", 32'(bus.ack), 32'd0);
    checkOutput("reset result", 32'(bus.result), 32'd0);
    checkOutput("reset carry", 32'(bus.carry), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset grant", 32'(bus.grant_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single request, 0x12 + 0x34 = 0x46; leaves ptr at 1.
    doOp("single", 0, 8'h12, 8'h34, 8'h46, 1'b0);

    // Reset during EXEC of requester 2: everything clears, no ack follows.
    applyStimulus(2, 8'h0A, 8'h0B);
    bus.req = 4'b0100;
    @(negedge clk);
    checkOutput("midrst grant", 32'(bus.grant_id), 32'd2);
    rst = 1'b1;
    bus.req = 4'b0000;
    #1;
    checkOutput("midrst busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst ack", 32'(bus.ack), 32'd0);
    checkOutput("midrst result", 32'(bus.result), 32'd0);
    checkOutput("midrst grant0", 32'(bus.grant_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ackCount = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.ack != 4'b0000) ackCount++;
    end
    checkOutput("midrst no ack", 32'(ackCount), 32'd0);

    // ptr must restart at 0: with req=0101, requester 0 wins first
    // (a surviving ptr of 1 would pick requester 2), then 2 is served.
    applyStimulus(0, 8'h01, 8'h02);
    applyStimulus(2, 8'h30, 8'h04);
    bus.req = 4'b0101;
    waitAck(cycles);
    checkOutput("postrst ack0", 32'(bus.ack), 32'b0001);
    checkOutput("postrst res0", 32'(bus.result), 32'h03);
    bus.req = 4'b0100;
    waitAck(cycles);
    checkOutput("postrst ack2", 32'(bus.ack), 32'b0100);
    checkOutput("postrst res2", 32'(bus.result), 32'h34);
    checkOutput("postrst lat2", 32'(cycles), 32'd3);
    bus.req = 4'b0000;
    @(negedge clk);

    // Wrap-around on requester 2.
    doOp("wrapFF", 2, 8'hFF, 8'h01, 8'h00, 1'b1);
    doOp("wrap80", 2, 8'h80, 8'h80, 8'h00, 1'b1);

    // Bring ptr back to 0 so the simultaneous case starts at requester 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // All four request together; each drops its bit on its own ack.
    for (int i = 0; i < 4; i++) applyStimulus(i, 8'(i), 8'h10);
    bus.req = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      waitAck(cycles);
      expAck = 4'b0001 << n;
      checkOutput("simul ack", 32'(bus.ack), 32'(expAck));
      checkOutput("simul result", 32'(bus.result), 32'(8'h10 + 8'(n)));
      checkOutput("simul slot", 32'(cycles), (n == 0) ? 32'd2 : 32'd3);
      bus.req = bus.req & ~expAck;
    end
    @(negedge clk);

    // Fairness: req[3] held, req[0] re-raised right after each ack.
    bus.req = 4'b1001;
    for (int n = 0; n < 4; n++) begin
      waitAck(cycles);
      expAck = (n % 2 == 0) ? 4'b0001 : 4'b1000;
      checkOutput("fair order", 32'(bus.ack), 32'(expAck));
      if (n == 3) begin
        bus.req = 4'b0000;
      end else if (expAck == 4'b0001) begin
        bus.req = 4'b1000;
        @(negedge clk);
        bus.req = 4'b1001;
      end
    end
    @(negedge clk);
    @(negedge clk);

    // Operand stability: op_a[1] changes and req[1] drops during EXEC.
    applyStimulus(1, 8'h21, 8'h05);
    bus.req = 4'b0010;
    @(negedge clk);
    checkOutput("stable grant", 32'(bus.grant_id), 32'd1);
    bus.op_a[15:8] = 8'h99;
    bus.req = 4'b0000;
    waitAck(cycles);
    checkOutput("stable ack", 32'(bus.ack), 32'b0010);
    checkOutput("stable result", 32'(bus.result), 32'h26);
    checkOutput("stable carry", 32'(bus.carry), 32'd0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
